sfif_wbm: RTL
=============

SFIF_WBM -- requirements
Module: sfif_wbm

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waited for ack/err/rty per bus cycle.
REQ-002 Parameter MAX_RETRY, default 3: max re-issues of one word after wb_rty_i.
REQ-003 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 cmd_start  in  1  one-cycle command strobe; sampled only in IDLE.
REQ-006 cmd_we  in  1  1 = write transfer, 0 = read transfer.
REQ-007 cmd_adr  in  18  start byte address.
REQ-008 cmd_len  in  11  word count; 0 encodes 2048.
REQ-009 wr_data  in  16  write-word stream data.
REQ-010 wr_valid  in  1  write-word available.
REQ-011 wr_ready  out  1  write word accepted this cycle.
REQ-012 rd_data  out  16  read-word stream data.
REQ-013 rd_valid  out  1  read word available.
REQ-014 rd_ready  in  1  downstream accepts read word.
REQ-015 busy  out  1  command in progress.
REQ-016 done  out  1  one-cycle pulse at completion or abort.
REQ-017 status  out  2  00 ok, 01 bus error, 10 retries exhausted, 11 timeout.
REQ-018 xfer_cnt  out  11  words completed in current/last command.
REQ-019 wb_adr_o out 18; wb_dat_o out 16; wb_sel_o out 2; wb_we_o, wb_cyc_o, wb_stb_o, wb_lock_o out 1: Wishbone master outputs.
REQ-020 wb_dat_i in 16; wb_ack_i, wb_err_i, wb_rty_i in 1: Wishbone master inputs.

Function
REQ-021 States SHALL be IDLE, FETCH, REQ, GAP, HOLD, DONE.
REQ-022 IDLE: cmd_start=1 latches cmd_*, clears xfer_cnt/status, sets busy next cycle; goes to FETCH if cmd_we else REQ.
REQ-023 cmd_start while busy SHALL be ignored.
REQ-024 FETCH: wr_ready=1 combinationally with wr_valid; on wr_valid&wr_ready latch wr_data into wb_dat_o, go REQ.
REQ-025 REQ: wb_cyc_o=wb_stb_o=1, wb_sel_o=2'b11, wb_we_o=latched cmd_we, wb_adr_o=current address; held stable until a termination input.
REQ-026 Outside REQ, wb_cyc_o, wb_stb_o, wb_we_o=0 and wb_sel_o=2'b00; wb_lock_o SHALL be 0 always.
REQ-027 Termination priority in REQ: wb_err_i > wb_ack_i > wb_rty_i.
REQ-028 Ack on read: capture wb_dat_i into rd_data, go HOLD; rd_valid=1 from next cycle until rd_valid&rd_ready.
REQ-029 Ack on write: go GAP.
REQ-030 Every acked word: xfer_cnt+1, address+2 (18-bit modulo wrap), retry count cleared.
REQ-031 GAP: one cycle with cyc/stb low between consecutive bus cycles (also after rty); next state FETCH/REQ, or DONE if last word.
REQ-032 HOLD: on rd_ready, go GAP (or DONE if last word); at most one read word buffered.
REQ-033 wb_rty_i: retry count+1, same address/data re-issued after GAP; if count reaches MAX_RETRY+1 abort status 10.
REQ-034 wb_err_i: abort status 01, word not counted.
REQ-035 Timeout counter reset on entering REQ; reaching TIMEOUT cycles in REQ without termination aborts status 11.
REQ-036 Abort: cyc/stb low next cycle, go DONE.
REQ-037 DONE: done=1 one cycle, busy=0 next cycle, return IDLE; status and xfer_cnt held until next accepted command.
REQ-038 cmd_len=0 SHALL transfer 2048 words; xfer_cnt wraps to 0 after 2048 (status still 00).

Reset
REQ-039 wb_rst_i=1 at any edge SHALL force IDLE; busy, done, rd_valid, wr_ready, wb_cyc_o, wb_stb_o, wb_we_o=0; wb_sel_o, status=0; wb_adr_o, wb_dat_o, rd_data, xfer_cnt, counters=0.
REQ-040 Reset mid-transfer SHALL drop cyc/stb at that edge, emit no done pulse, discard buffered data.

Verification
REQ-041 Read cmd_adr=0x02000, len=4, slave acks 1 cycle after stb, rd_ready=1 -> adr 0x02000/02/04/06, 4 rd_valid words, 1-cycle gap each, done, status 00, xfer_cnt 4.
REQ-042 Write len=3, wr_valid held low 5 cycles then high -> no stb until wr_valid; 3 writes with wr_data, wb_we_o=1, done, status 00.
REQ-043 Slave asserts rty twice then ack -> same address issued 3 times, xfer_cnt 1, status 00; rty 4 times -> abort status 10, xfer_cnt 0.
REQ-044 Slave never responds, TIMEOUT=16 -> cyc drops after 16 cycles, done pulse, status 11; ack+err same cycle -> status 01.
REQ-045 Read cmd_adr=0x3FFFE len=2 with rd_ready low 10 cycles -> second address 0x00000 issued only after first word accepted; reset asserted during second REQ -> cyc low, no done, all outputs 0.

Source files
------------

// File: rtl/sfif_wbm.sv
// Stream-to-Wishbone master: turns a (we, adr, len) command into a sequence of single-word
// classic Wishbone cycles, fed by a write-word stream or draining into a read-word stream.
// Each bus cycle is followed by a one-cycle idle gap. Retries, bus errors and a per-cycle
// timeout are handled, and the outcome is reported through status/xfer_cnt.
module sfif_wbm #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // Command interface
  input  logic        cmd_start,
  input  logic        cmd_we,
  input  logic [17:0] cmd_adr,
  input  logic [10:0] cmd_len,
  // Write-word stream
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  // Read-word stream
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  // Status
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [10:0] xfer_cnt,
  // Wishbone master
  output logic [17:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_lock_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned RtyW = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic            we_q, we_d;
  logic [17:0]     adr_q, adr_d;
  // Words still to be acked; 12 bits so a length of 2048 fits.
  logic [11:0]     rem_q, rem_d;
  logic [10:0]     cnt_q, cnt_d;
  logic [1:0]      status_q, status_d;
  logic [15:0]     wdat_q, wdat_d;
  logic [15:0]     rdat_q, rdat_d;
  logic [RtyW-1:0] rty_q, rty_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Next-state logic: command capture, bus-cycle termination handling and sequencing.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    adr_d    = adr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    rty_d    = rty_q;
    // Timeout counter only runs while a bus cycle is outstanding.
    tmo_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          we_d     = cmd_we;
          adr_d    = cmd_adr;
          rem_d    = (cmd_len == 11'd0) ? 12'd2048 : {1'b0, cmd_len};
          cnt_d    = '0;
          status_d = 2'b00;
          rty_d    = '0;
          state_d  = cmd_we ? FETCH : REQ;
        end
      end
      FETCH: begin
        if (wr_valid) begin
          wdat_d  = wr_data;
          state_d = REQ;
        end
      end
      REQ: begin
        tmo_d = tmo_q + TmoW'(1);
        if (wb_err_i) begin
          status_d = 2'b01;
          state_d  = DONE;
        end else if (wb_ack_i) begin
          cnt_d = cnt_q + 11'd1;
          adr_d = adr_q + 18'd2;
          rem_d = rem_q - 12'd1;
          rty_d = '0;
          if (we_q) begin
            state_d = GAP;
          end else begin
            rdat_d  = wb_dat_i;
            state_d = HOLD;
          end
        end else if (wb_rty_i) begin
          rty_d = rty_q + RtyW'(1);
          if (rty_q == RtyW'(MAX_RETRY)) begin
            status_d = 2'b10;
            state_d  = DONE;
          end else begin
            state_d = GAP;
          end
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          status_d = 2'b11;
          state_d  = DONE;
        end
      end
      GAP: begin
        // A pending retry re-issues the already latched write word without refetching.
        if (rem_q == 12'd0) begin
          state_d = DONE;
        end else if (we_q && (rty_q == '0)) begin
          state_d = FETCH;
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (rd_ready) begin
          state_d = (rem_q == 12'd0) ? DONE : GAP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      status_q <= 2'b00;
      wdat_q   <= '0;
      rdat_q   <= '0;
      rty_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      rty_q    <= rty_d;
      tmo_q    <= tmo_d;
    end
  end

  // Outputs decoded from the current state and registers.
  always_comb begin
    wr_ready  = (state_q == FETCH) && wr_valid;
    rd_valid  = (state_q == HOLD);
    rd_data   = rdat_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    status    = status_q;
    xfer_cnt  = cnt_q;
    wb_cyc_o  = (state_q == REQ);
    wb_stb_o  = (state_q == REQ);
    wb_we_o   = (state_q == REQ) && we_q;
    wb_sel_o  = (state_q == REQ) ? 2'b11 : 2'b00;
    wb_lock_o = 1'b0;
    wb_adr_o  = adr_q;
    wb_dat_o  = wdat_q;
  end

endmodule
